// File: rtl/io_bus_router.sv
// Decodes core bus accesses against base/mask regions and runs each as a req/ready transaction.
// Optional timeout counter and timeout-error path built when IO_BUS_ROUTER_TIMEOUT_EN is defined.
module io_bus_router #(
  parameter int unsigned                  N_SLAVES = 4,
  parameter int unsigned                  ADDR_W   = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0]   SLV_BASE = {32'hFFFFFD00, 32'hFFFFFE00,
                                                      32'h80000000, 32'h00000000},
  parameter logic [N_SLAVES*ADDR_W-1:0]   SLV_MASK = {32'hFFFFFF00, 32'hFFFFFF00,
                                                      32'hFFF00000, 32'h00000000},
  parameter int unsigned                  TIMEOUT  = 16,
  parameter int unsigned                  SEL_W    = $clog2(N_SLAVES + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m_req,
  input  logic                m_we,
  input  logic [ADDR_W-1:0]   m_addr,
  input  logic                stall_in,
  output logic                m_ready,
  output logic                m_err,
  output logic [SEL_W-1:0]    m_rsel,
  output logic [N_SLAVES-1:0] s_req,
  output logic [N_SLAVES-1:0] wr_select,
  input  logic [N_SLAVES-1:0] s_ready,
  output logic [7:0]          err_count
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic [7:0]       err_count_q, err_count_d;
  logic             hit;
  logic [SEL_W-1:0] hit_idx;
  logic             sel_ready;
  logic             timeout;

  // Descending scan so the lowest-index hit is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = SEL_W'(N_SLAVES);
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((SLV_MASK[i*ADDR_W +: ADDR_W] != '0) &&
          ((m_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
           (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W]))) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

`ifdef IO_BUS_ROUTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A stalled cycle never times out; it only holds the count.
  assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1)) && !stall_in;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if ((state_q == StBusy) && !stall_in) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;

  assign timeout        = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  assign sel_ready = |(s_req & s_ready);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    we_d        = we_q;
    err_d       = err_q;
    err_count_d = err_count_q;
    unique case (state_q)
      StIdle: begin
        if (m_req && !stall_in) begin
          we_d  = m_we;
          idx_d = hit_idx;
          err_d = !hit;
          state_d = hit ? StBusy : StResp;
        end
      end
      StBusy: begin
        if (sel_ready) begin
          err_d   = 1'b0;
          state_d = StResp;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (err_q && (err_count_q != 8'hFF)) begin
          err_count_d = err_count_q + 8'd1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= SEL_W'(N_SLAVES);
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      we_q        <= we_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    s_req = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      s_req[i] = (state_q == StBusy) && (idx_q == SEL_W'(i));
    end
  end

  assign wr_select = s_req & {N_SLAVES{we_q}};
  assign m_ready   = (state_q == StResp);
  assign m_err     = (state_q == StResp) && err_q;
  assign m_rsel    = idx_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_io_bus_router.sv
// Bench for io_bus_router: vector table, hand sequences and random transactions vs a model.
module tb_io_bus_router;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        reset;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic        stall_in;
  logic        m_ready;
  logic        m_err;
  logic [2:0]  m_rsel;
  logic [3:0]  s_req;
  logic [3:0]  wr_select;
  logic [3:0]  s_ready;
  logic [7:0]  err_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int model_errcnt = 0;

  logic [31:0] base [4];
  logic [31:0] mask [4];

  typedef struct {
    logic [31:0] addr;
    logic        we;
    int          ready_at;
    int          nstall;
    int          pre_stall;
    int          exp_idx;
    logic        exp_err;
    int          exp_resp;
  } vec_t;

  vec_t vecs [11];

  io_bus_router #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .stall_in  (stall_in),
    .m_ready   (m_ready),
    .m_err     (m_err),
    .m_rsel    (m_rsel),
    .s_req     (s_req),
    .wr_select (wr_select),
    .s_ready   (s_ready),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required to finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: first matching region wins; timeout after TIMEOUT unstalled BUSY cycles.
  function automatic void predict(input logic [31:0] addr, input int ready_at, input int nstall,
                                  output int idx, output logic err, output int resp);
    int t_to;
    int n;
    idx = 4;
    for (int i = 0; i < 4; i++) begin
      if (mask[i] != 0 && (addr & mask[i]) == (base[i] & mask[i])) begin
        idx = i;
        break;
      end
    end
    if (idx == 4) begin
      err  = 1'b1;
      resp = 1;
      return;
    end
    t_to = 0;
`ifdef IO_BUS_ROUTER_TIMEOUT_EN
    n = 0;
    for (int t = 1; t < 1000; t++) begin
      if (!(t >= 2 && t < 2 + nstall)) n++;
      if (n == TIMEOUT) begin
        t_to = t;
        break;
      end
    end
`else
    n = nstall;
`endif
    if (ready_at != 0 && (t_to == 0 || ready_at <= t_to)) begin
      err  = 1'b0;
      resp = ready_at + 1;
    end else begin
      err  = 1'b1;
      resp = t_to + 1;
    end
  endfunction

  task automatic run_txn(input string name, input logic [31:0] addr, input logic we,
                         input int ready_at, input int nstall, input int pre_stall,
                         input int exp_idx, input logic exp_err, input int exp_resp);
    logic [3:0] oh;
    logic [3:0] noise;
    int         resp_c;
    oh = (exp_idx < 4) ? 4'(1 << exp_idx) : 4'b0000;
    m_addr = addr;
    m_we   = we;
    m_req  = 1'b1;
    for (int p = 0; p < pre_stall; p++) begin
      stall_in = 1'b1;
      tick();
      check({name, " stalled_idle_sreq"}, 32'(s_req), 32'h0);
      check({name, " stalled_idle_ready"}, 32'(m_ready), 32'h0);
    end
    stall_in = 1'b0;
    noise    = 4'($urandom);
    s_ready  = noise & ~oh;
    tick();
    resp_c = 0;
    for (int c = 1; c <= 200; c++) begin
      if (m_ready) begin
        resp_c = c;
        break;
      end
      check({name, " busy_sreq"}, 32'(s_req), 32'(oh));
      check({name, " busy_wrsel"}, 32'(wr_select), we ? 32'(oh) : 32'h0);
      check({name, " busy_rsel"}, 32'(m_rsel), 32'(exp_idx));
      noise    = 4'($urandom);
      s_ready  = (noise & ~oh) | ((c == ready_at) ? oh : 4'b0000);
      stall_in = (c >= 2) && (c < 2 + nstall);
      tick();
    end
    m_req    = 1'b0;
    stall_in = 1'b0;
    s_ready  = 4'b0000;
    if (resp_c == 0) begin
      errors++;
      checks++;
      $display("FAIL %s no_response: no m_ready within 200 cycles, expected at %0d",
               name, exp_resp);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_errcnt = 0;
      return;
    end
    check({name, " resp_cycle"}, 32'(resp_c), 32'(exp_resp));
    check({name, " resp_err"}, 32'(m_err), 32'(exp_err));
    check({name, " resp_rsel"}, 32'(m_rsel), 32'(exp_idx));
    check({name, " resp_sreq"}, 32'({s_req, wr_select}), 32'h0);
    if (exp_err && model_errcnt < 255) model_errcnt++;
    tick();
    check({name, " idle_ready"}, 32'(m_ready), 32'h0);
    check({name, " hold_rsel"}, 32'(m_rsel), 32'(exp_idx));
    check({name, " err_count"}, 32'(err_count), 32'(model_errcnt));
  endtask

  initial begin
    int   idx;
    logic err;
    int   resp;
    logic [31:0] addr;
    int   ready_at;
    int   nstall;
    int   sel;

    base[0] = 32'h00000000; mask[0] = 32'h00000000;
    base[1] = 32'h80000000; mask[1] = 32'hFFF00000;
    base[2] = 32'hFFFFFE00; mask[2] = 32'hFFFFFF00;
    base[3] = 32'hFFFFFD00; mask[3] = 32'hFFFFFF00;

    vecs[0]  = '{32'h80000010, 1'b0, 1,   0, 0, 1, 1'b0, 2};
    vecs[1]  = '{32'hFFFFFE04, 1'b1, 2,   0, 0, 2, 1'b0, 3};
    vecs[2]  = '{32'h40000000, 1'b0, 1,   0, 0, 4, 1'b1, 1};
`ifdef IO_BUS_ROUTER_TIMEOUT_EN
    vecs[3]  = '{32'hFFFFFD08, 1'b0, 101, 0, 0, 3, 1'b1, 17};
    vecs[4]  = '{32'hFFFFFD10, 1'b1, 101, 3, 0, 3, 1'b1, 20};
`else
    vecs[3]  = '{32'hFFFFFD08, 1'b0, 101, 0, 0, 3, 1'b0, 102};
    vecs[4]  = '{32'hFFFFFD10, 1'b1, 101, 3, 0, 3, 1'b0, 102};
`endif
    vecs[5]  = '{32'hFFFFFDFC, 1'b0, 16,  0, 0, 3, 1'b0, 17};
    vecs[6]  = '{32'h800FFFFF, 1'b1, 3,   0, 2, 1, 1'b0, 4};
    vecs[7]  = '{32'h80100000, 1'b0, 1,   0, 0, 4, 1'b1, 1};
    vecs[8]  = '{32'hFFFFFF00, 1'b1, 1,   0, 0, 4, 1'b1, 1};
    vecs[9]  = '{32'hFFFFFE00, 1'b1, 5,   2, 0, 2, 1'b0, 6};
    vecs[10] = '{32'h00000000, 1'b0, 1,   0, 0, 4, 1'b1, 1};

    reset = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = '0; stall_in = 1'b0; s_ready = '0;
    tick();
    tick();
    check("reset_ready", 32'(m_ready), 32'h0);
    check("reset_err", 32'(m_err), 32'h0);
    check("reset_sreq", 32'(s_req), 32'h0);
    check("reset_wrsel", 32'(wr_select), 32'h0);
    check("reset_rsel", 32'(m_rsel), 32'h4);
    check("reset_errcnt", 32'(err_count), 32'h0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 11; v++) begin
      run_txn($sformatf("vec%0d", v), vecs[v].addr, vecs[v].we, vecs[v].ready_at,
              vecs[v].nstall, vecs[v].pre_stall, vecs[v].exp_idx, vecs[v].exp_err,
              vecs[v].exp_resp);
    end

    // Reset while BUSY: request drops at once and no completion follows.
    m_addr = 32'h80000004; m_we = 1'b1; m_req = 1'b1;
    tick();
    check("rst_busy_sreq", 32'(s_req), 32'h2);
    m_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_errcnt = 0;
    check("rst_mid_sreq", 32'(s_req), 32'h0);
    check("rst_mid_wrsel", 32'(wr_select), 32'h0);
    check("rst_mid_ready", 32'(m_ready), 32'h0);
    check("rst_mid_rsel", 32'(m_rsel), 32'h4);
    for (int i = 0; i < 3; i++) begin
      s_ready = 4'hF;
      tick();
      check("rst_after_ready", 32'(m_ready), 32'h0);
    end
    s_ready = 4'h0;

    for (int r = 0; r < 40; r++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       addr = 32'h80000000 | 32'($urandom_range(0, 32'h000FFFFF));
        1:       addr = 32'hFFFFFE00 | 32'($urandom_range(0, 255));
        2:       addr = 32'hFFFFFD00 | 32'($urandom_range(0, 255));
        default: addr = $urandom;
      endcase
      ready_at = $urandom_range(1, 24);
      nstall   = $urandom_range(0, 3);
      predict(addr, ready_at, nstall, idx, err, resp);
      run_txn($sformatf("rnd%0d", r), addr, 1'($urandom), ready_at, nstall,
              $urandom_range(0, 2), idx, err, resp);
    end

    for (int m = 0; m < 300; m++) begin
      run_txn("sat_miss", 32'h40000000 + 32'(m), 1'b0, 1, 0, 0, 4, 1'b1, 1);
    end
    check("err_count_saturated", 32'(err_count), 32'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
